// File: rtl/game_flow_ctrl_if.sv
// Game flow controller signal bundle: frame/key/player status in, phase and
// timer out. master = stimulus/game side, slave = game_flow_ctrl.
//
// Signals:
//   frame_tick    1-cycle pulse per video frame
//   key_any       level, any key held by either player
//   num_eat_blue  blue diamonds collected (4b)
//   num_eat_red   red diamonds collected (4b)
//   boy_at_door   boy overlaps his exit door
//   girl_at_door  girl overlaps her exit door
//   boy_dead      boy touched a lethal hazard
//   girl_dead     girl touched a lethal hazard
//   game_state    0 TITLE 1 CLEAR 2 PLAY 3 EXIT_WAIT 4 WIN 5 LOSE_ANIM 6 LOSE
//   play_en       movement / physics enable
//   diamond_clear 1-cycle clear for the diamond collision FSMs
//   timer_sec     elapsed seconds this round (10b)
//   win           high in WIN
//   lose          high in LOSE_ANIM and LOSE
interface game_flow_ctrl_if;
    logic       frame_tick;
    logic       key_any;
    logic [3:0] num_eat_blue;
    logic [3:0] num_eat_red;
    logic       boy_at_door;
    logic       girl_at_door;
    logic       boy_dead;
    logic       girl_dead;
    logic [2:0] game_state;
    logic       play_en;
    logic       diamond_clear;
    logic [9:0] timer_sec;
    logic       win;
    logic       lose;

    modport master (
        output frame_tick, key_any,
        output num_eat_blue, num_eat_red,
        output boy_at_door, girl_at_door,
        output boy_dead, girl_dead,
        input  game_state, play_en, diamond_clear,
        input  timer_sec, win, lose
    );

    modport slave (
        input  frame_tick, key_any,
        input  num_eat_blue, num_eat_red,
        input  boy_at_door, girl_at_door,
        input  boy_dead, girl_dead,
        output game_state, play_en, diamond_clear,
        output timer_sec, win, lose
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: title -> clear -> play -> exit wait -> win/lose,
// with a per-round seconds timer driven by the frame tick.
//
// Ports:
//   Clk    system clock
//   Reset  synchronous, active-high
//   bus    game_flow_ctrl_if.slave (see interface file for signal list)
module game_flow_ctrl #(
    parameter int FRAMES_PER_SEC    = 60,
    parameter int TOTAL_BLUE        = 3,
    parameter int TOTAL_RED         = 3,
    parameter int DOOR_HOLD_FRAMES  = 30,
    parameter int LOSE_DELAY_FRAMES = 90,
    parameter int TIME_LIMIT        = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    game_flow_ctrl_if.slave   bus
);

    localparam int FW = $clog2(FRAMES_PER_SEC + 1);
    localparam int HW = $clog2(DOOR_HOLD_FRAMES + 1);
    localparam int LW = $clog2(LOSE_DELAY_FRAMES + 1);
    localparam logic [9:0] TIMER_MAX = 10'd999;

    typedef enum logic [2:0] {
        S_TITLE     = 3'd0,
        S_CLEAR     = 3'd1,
        S_PLAY      = 3'd2,
        S_EXIT_WAIT = 3'd3,
        S_WIN       = 3'd4,
        S_LOSE_ANIM = 3'd5,
        S_LOSE      = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_key_q;
    logic            r_key_ok;
    logic [FW-1:0]   r_frame_cnt;
    logic [9:0]      r_timer_sec;
    logic [HW-1:0]   r_hold_cnt;
    logic [LW-1:0]   r_lose_cnt;

    logic            w_key_edge;
    logic            w_all_gems;
    logic            w_at_doors;
    logic            w_dead;
    logic            w_time_up;
    logic            w_exit_ok;
    logic            w_lose_now;
    logic            w_hold_last;
    logic            w_lose_last;
    logic            w_frame_last;
    logic            w_timer_run;
    logic            w_enter_clear;

    // r_key_ok only arms after key_any has been seen low, so a key held
    // through reset cannot look like a fresh press.
    assign w_key_edge   = bus.key_any & ~r_key_q & r_key_ok;
    assign w_all_gems   = (bus.num_eat_blue >= 4'(TOTAL_BLUE)) &&
                          (bus.num_eat_red  >= 4'(TOTAL_RED));
    assign w_at_doors   = bus.boy_at_door && bus.girl_at_door;
    assign w_dead       = bus.boy_dead || bus.girl_dead;
    assign w_time_up    = (TIME_LIMIT != 0) &&
                          (r_timer_sec == 10'(TIME_LIMIT));
    assign w_exit_ok    = w_all_gems && w_at_doors;
    assign w_lose_now   = w_dead || w_time_up;
    assign w_hold_last  = (r_hold_cnt == HW'(DOOR_HOLD_FRAMES - 1));
    assign w_lose_last  = (r_lose_cnt == LW'(LOSE_DELAY_FRAMES - 1));
    assign w_frame_last = (r_frame_cnt == FW'(FRAMES_PER_SEC - 1));
    assign w_timer_run  = (r_state == S_PLAY) ||
                          (r_state == S_EXIT_WAIT);
    assign w_enter_clear = (w_next == S_CLEAR) &&
                           (r_state != S_CLEAR);

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_TITLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; death and timeout always beat the exit path
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_TITLE: begin
                if (w_key_edge) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                w_next = S_PLAY;
            end
            S_PLAY: begin
                if (w_lose_now)     w_next = S_LOSE_ANIM;
                else if (w_exit_ok) w_next = S_EXIT_WAIT;
            end
            S_EXIT_WAIT: begin
                if (w_lose_now)      w_next = S_LOSE_ANIM;
                else if (!w_exit_ok) w_next = S_PLAY;
                else if (bus.frame_tick && w_hold_last)
                    w_next = S_WIN;
            end
            S_WIN, S_LOSE: begin
                if (w_key_edge) w_next = S_CLEAR;
            end
            S_LOSE_ANIM: begin
                if (bus.frame_tick && w_lose_last)
                    w_next = S_LOSE;
            end
            default: begin
                w_next = S_TITLE;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        bus.game_state    = r_state;
        bus.play_en       = 1'b0;
        bus.diamond_clear = 1'b0;
        bus.win           = 1'b0;
        bus.lose          = 1'b0;
        unique case (r_state)
            S_CLEAR:     bus.diamond_clear = 1'b1;
            S_PLAY:      bus.play_en       = 1'b1;
            S_EXIT_WAIT: bus.play_en       = 1'b1;
            S_WIN:       bus.win           = 1'b1;
            S_LOSE_ANIM: bus.lose          = 1'b1;
            S_LOSE:      bus.lose          = 1'b1;
            default:     ;
        endcase
    end

    assign bus.timer_sec = r_timer_sec;

    // Key edge detector
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_q  <= 1'b0;
            r_key_ok <= 1'b0;
        end else begin
            r_key_q <= bus.key_any;
            if (!bus.key_any) r_key_ok <= 1'b1;
        end
    end

    // Round timer; frozen outside PLAY/EXIT_WAIT so the final time stays
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_cnt <= '0;
            r_timer_sec <= '0;
        end else if (w_enter_clear) begin
            r_frame_cnt <= '0;
            r_timer_sec <= '0;
        end else if (w_timer_run && bus.frame_tick) begin
            if (w_frame_last) begin
                r_frame_cnt <= '0;
                if (r_timer_sec != TIMER_MAX)
                    r_timer_sec <= r_timer_sec + 10'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end

    // Door hold counter: only accumulates while staying in EXIT_WAIT,
    // so any exit (back to PLAY, WIN, LOSE_ANIM) leaves it at zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hold_cnt <= '0;
        end else if ((r_state == S_EXIT_WAIT) &&
                     (w_next == S_EXIT_WAIT)) begin
            if (bus.frame_tick) r_hold_cnt <= r_hold_cnt + HW'(1);
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // Death animation counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lose_cnt <= '0;
        end else if ((r_state == S_LOSE_ANIM) &&
                     (w_next == S_LOSE_ANIM)) begin
            if (bus.frame_tick) r_lose_cnt <= r_lose_cnt + LW'(1);
        end else begin
            r_lose_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: default instance A plus a
// short-timer instance B (TIME_LIMIT=2, FRAMES_PER_SEC=4).
module tb_game_flow_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    game_flow_ctrl_if ia ();
    game_flow_ctrl_if ib ();

    game_flow_ctrl u_a (.Clk(Clk), .Reset(Reset), .bus(ia.slave));
    game_flow_ctrl #(
        .FRAMES_PER_SEC(4),
        .TIME_LIMIT(2)
    ) u_b (.Clk(Clk), .Reset(Reset), .bus(ib.slave));

    localparam int F_ST = 0;
    localparam int F_PE = 1;
    localparam int F_DC = 2;
    localparam int F_TM = 3;
    localparam int F_WN = 4;
    localparam int F_LS = 5;

    typedef struct {
        bit    sel;
        int    fld;
        int    val;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int obs(input bit s, input int f);
        int v;
        v = 0;
        case (f)
            F_ST: v = s ? int'(ib.game_state)    : int'(ia.game_state);
            F_PE: v = s ? int'(ib.play_en)       : int'(ia.play_en);
            F_DC: v = s ? int'(ib.diamond_clear) : int'(ia.diamond_clear);
            F_TM: v = s ? int'(ib.timer_sec)     : int'(ia.timer_sec);
            F_WN: v = s ? int'(ib.win)           : int'(ia.win);
            F_LS: v = s ? int'(ib.lose)          : int'(ia.lose);
            default: v = -1;
        endcase
        return v;
    endfunction

    task automatic push(input bit s, input int f, input int v,
                        input string t);
        exp_t e;
        e.sel = s; e.fld = f; e.val = v; e.tag = t;
        q.push_back(e);
    endtask

    task automatic push_all(input bit s, input int st, input int pe,
                            input int dc, input int tm, input int wn,
                            input int ls, input string t);
        push(s, F_ST, st, {t, ".st"});
        push(s, F_PE, pe, {t, ".pe"});
        push(s, F_DC, dc, {t, ".dc"});
        push(s, F_TM, tm, {t, ".tm"});
        push(s, F_WN, wn, {t, ".win"});
        push(s, F_LS, ls, {t, ".lose"});
    endtask

    // One clock; everything queued for this edge is compared after it
    task automatic cyc();
        exp_t e;
        @(posedge Clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, obs(e.sel, e.fld), e.val);
        end
    endtask

    task automatic set_tick(input bit s, input logic v);
        if (s) ib.frame_tick = v;
        else   ia.frame_tick = v;
    endtask

    task automatic tick_n(input bit s, input int n);
        for (int i = 0; i < n; i++) begin
            set_tick(s, 1'b1);
            cyc();
            set_tick(s, 1'b0);
            cyc();
        end
    endtask

    task automatic idle_bus_a();
        ia.frame_tick = 0; ia.key_any = 0;
        ia.num_eat_blue = 0; ia.num_eat_red = 0;
        ia.boy_at_door = 0; ia.girl_at_door = 0;
        ia.boy_dead = 0; ia.girl_dead = 0;
    endtask

    task automatic idle_bus_b();
        ib.frame_tick = 0; ib.key_any = 0;
        ib.num_eat_blue = 0; ib.num_eat_red = 0;
        ib.boy_at_door = 0; ib.girl_at_door = 0;
        ib.boy_dead = 0; ib.girl_dead = 0;
    endtask

    initial begin
        idle_bus_a();
        idle_bus_b();
        Reset = 1'b1;
        ia.key_any = 1'b1;
        cyc();
        cyc();
        push_all(0, 0, 0, 0, 0, 0, 0, "rst_a");
        push_all(1, 0, 0, 0, 0, 0, 0, "rst_b");
        cyc();

        // key held across reset release: no start
        Reset = 1'b0;
        cyc();
        cyc();
        push(0, F_ST, 0, "held_key");
        cyc();
        ia.key_any = 1'b0;
        cyc();
        ia.key_any = 1'b1;
        push_all(0, 1, 0, 1, 0, 0, 0, "clr");
        cyc();
        push_all(0, 2, 1, 0, 0, 0, 0, "play");
        cyc();
        ia.key_any = 1'b0;

        // 150 ticks -> 2 s, then death
        tick_n(0, 150);
        push(0, F_ST, 2, "t150.st");
        push(0, F_TM, 2, "t150.tm");
        cyc();
        ia.boy_dead = 1'b1;
        push_all(0, 5, 0, 0, 2, 0, 1, "dead");
        cyc();
        ia.boy_dead = 1'b0;
        tick_n(0, 89);
        push(0, F_ST, 5, "anim89");
        cyc();
        ia.frame_tick = 1'b1;
        push_all(0, 6, 0, 0, 2, 0, 1, "lose");
        cyc();
        ia.frame_tick = 1'b0;

        // new round from LOSE
        ia.key_any = 1'b1;
        push_all(0, 1, 0, 1, 0, 0, 0, "reclr");
        cyc();
        ia.key_any = 1'b0;
        push_all(0, 2, 1, 0, 0, 0, 0, "replay");
        cyc();

        // door hold broken on the 30th tick, then completed
        ia.num_eat_blue = 4'd3;
        ia.num_eat_red  = 4'd3;
        ia.boy_at_door  = 1'b1;
        ia.girl_at_door = 1'b1;
        push(0, F_ST, 3, "exitw");
        cyc();
        tick_n(0, 29);
        push(0, F_ST, 3, "hold29");
        cyc();
        ia.girl_at_door = 1'b0;
        ia.frame_tick = 1'b1;
        push(0, F_ST, 2, "drop30");
        cyc();
        ia.frame_tick = 1'b0;
        ia.girl_at_door = 1'b1;
        push(0, F_ST, 3, "exitw2");
        cyc();
        tick_n(0, 29);
        ia.frame_tick = 1'b1;
        push_all(0, 4, 0, 0, 1, 1, 0, "win");
        cyc();
        ia.frame_tick = 1'b0;
        tick_n(0, 5);
        push(0, F_ST, 4, "win_hold.st");
        push(0, F_TM, 1, "win_frozen.tm");
        cyc();

        // one red short: never leaves PLAY
        ia.num_eat_red = 4'd2;
        ia.key_any = 1'b1;
        push(0, F_ST, 1, "clr3");
        cyc();
        ia.key_any = 1'b0;
        push(0, F_ST, 2, "play3");
        cyc();
        for (int i = 0; i < 40; i++) begin
            ia.frame_tick = 1'b1;
            push(0, F_ST, 2, "nogem");
            cyc();
            ia.frame_tick = 1'b0;
            cyc();
        end

        // death on the same tick that would win
        ia.num_eat_red = 4'd3;
        push(0, F_ST, 3, "exitw3");
        cyc();
        tick_n(0, 29);
        ia.girl_dead = 1'b1;
        ia.frame_tick = 1'b1;
        push(0, F_ST, 5, "dvw.st");
        push(0, F_WN, 0, "dvw.win");
        cyc();
        ia.girl_dead = 1'b0;
        ia.frame_tick = 1'b0;

        // instance B: time limit 2 s at 4 frames/s
        ib.key_any = 1'b1;
        push(1, F_ST, 1, "b_clr");
        push(1, F_DC, 1, "b_clr.dc");
        cyc();
        ib.key_any = 1'b0;
        push(1, F_ST, 2, "b_play");
        cyc();
        tick_n(1, 7);
        push(1, F_ST, 2, "b_t7.st");
        push(1, F_TM, 1, "b_t7.tm");
        cyc();
        ib.frame_tick = 1'b1;
        push(1, F_ST, 2, "b_t8.st");
        push(1, F_TM, 2, "b_t8.tm");
        cyc();
        ib.frame_tick = 1'b0;
        push_all(1, 5, 0, 0, 2, 0, 1, "b_tlim");
        cyc();
        tick_n(1, 90);
        push(1, F_ST, 6, "b_lose");
        cyc();
        ib.key_any = 1'b1;
        push_all(1, 1, 0, 1, 0, 0, 0, "b_reclr");
        cyc();
        ib.key_any = 1'b0;
        push_all(1, 2, 1, 0, 0, 0, 0, "b_replay");
        cyc();
        tick_n(1, 5);
        push(1, F_TM, 1, "b_t5.tm");
        cyc();
        Reset = 1'b1;
        push_all(1, 0, 0, 0, 0, 0, 0, "b_midrst");
        cyc();
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
